decomp_flit_sequencer: RTL
==========================

// Module: decomp_flit_sequencer
// PURPOSE
//  Per-packet controller for the flit decompressor datapath. Latches the base/encoding
//  metadata carried in each head flit and steps through one base/encoding pair per body
//  flit. Drives the datapath inputs, then registers the datapath result into a
//  valid/ready output stage. Sits between the router ejection port and the decompressor.
// PARAMETERS
//  FLIT_W     128  flit width; equals the datapath INPUT_WIDTH and OUTPUT_WIDTH
//  CHUNK_SIZE 8    base width, in bits
//  EN_BITS    3    encoding-field width, in bits
//  NUM_PAIRS  4    number of base/encoding pairs carried in the head flit
//  PAIR_W     EN_BITS+CHUNK_SIZE (11); metadata occupies head bits [NUM_PAIRS*PAIR_W-1:0]
// PORTS
//  clk_in      in   1           clock; all state updates on the rising edge
//  rst_n       in   1           asynchronous active-low reset
//  in_valid    in   1           input flit valid
//  in_ready    out  1           input flit accepted when in_valid && in_ready
//  in_is_head  in   1           flit is a head flit (carries metadata)
//  in_is_tail  in   1           flit is the last flit of its packet; head+tail = 1-flit packet
//  in_data     in   FLIT_W      input flit
//  dp_data     out  FLIT_W      to datapath data_in; equals in_data, combinational
//  dp_en_bits  out  EN_BITS     to datapath: encoding of the current pair
//  dp_base     out  CHUNK_SIZE  to datapath: base of the current pair
//  dp_result   in   FLIT_W      from datapath data_out; combinational in dp_*
//  out_valid   out  1           output flit valid
//  out_ready   in   1           downstream ready
//  out_is_head out  1           registered in_is_head
//  out_is_tail out  1           registered in_is_tail
//  out_data    out  FLIT_W      registered: raw head flit, or dp_result for a body flit
//  err_orphan  out  1           sticky: body flit arrived in IDLE
//  err_notail  out  1           sticky: head flit arrived in BODY (previous tail missing)
// BEHAVIOUR
//  Reset: state=IDLE; pair_idx=0; metadata=0; out_valid=0; out_data=0; out_is_head=0;
//   out_is_tail=0; err_orphan=0; err_notail=0. Reset mid-packet discards the packet.
//  Handshake: in_ready = !out_valid || out_ready. One output register stage.
//   A flit accepted in cycle N gives out_valid in cycle N+1.
//   Full throughput: accept and drain in the same cycle is allowed.
//   out_* hold stable while out_valid && !out_ready.
//  Pair fields: pair p is meta[(NUM_PAIRS-p)*PAIR_W-1 -: PAIR_W]; pair 0 is the most
//   significant pair. en = pair[PAIR_W-1:CHUNK_SIZE]; base = pair[CHUNK_SIZE-1:0].
//  dp_en_bits/dp_base select pair pair_idx from the latched metadata.
//  FSM (transitions only on accepted flits):
//   IDLE + head, !tail: latch metadata from in_data; pair_idx<=0; forward raw; ->BODY.
//   IDLE + head + tail: forward raw; metadata unchanged; stay IDLE.
//   IDLE + body: drop (consumed, out_valid not set); err_orphan<=1; stay IDLE.
//   BODY + body: out_data<=dp_result; pair_idx<=(pair_idx==NUM_PAIRS-1)?0:pair_idx+1;
//    tail ->IDLE, else stay BODY.
//   BODY + head: err_notail<=1; then handled exactly as IDLE + head, same cycle.
//  Body flits use the pre-increment pair_idx; pair_idx wraps modulo NUM_PAIRS.
//  Error flags clear only on reset.
// STRUCTURE
//  decomp_pkg: PAIR_W, metadata field offsets, and the state enum {IDLE, BODY}.
//  Sub-module decomp_meta_reg: metadata latch with pair_idx mux (load, select in; en/base out).
//  Top level: FSM, pair counter, output register, error flags.
// TESTING
//  T1 head meta={p0=(3,'h10),p1=(1,'h05),p2=(0,'h00),p3=(2,'hFF)}, 5 bodies, no stall ->
//     head out raw at N+1; bodies see (en,base) = p0,p1,p2,p3,p0 (wrap); back to IDLE after tail
//  T2 head+tail single flit -> forwarded raw, state stays IDLE, metadata unchanged
//  T3 out_ready=0 for 3 cycles mid-packet -> in_ready=0; out_data stable;
//     no flit lost or duplicated
//  T4 body flit in IDLE -> no output, err_orphan=1; next packet decodes normally
//  T5 head, 2 bodies, new head without tail -> err_notail=1; pair_idx=0;
//     new metadata used by the next body
//  T6 rst_n low during BODY with out_valid=1 -> out_valid=0 at once (async);
//     next body after reset flags err_orphan

Source files
------------

// File: rtl/decomp_pkg.sv
// Shared definitions for the flit decompressor sequencer: default sizes,
// the head-flit metadata layout helpers and the packet state enum.
package decomp_pkg;

    localparam int DEF_FLIT_W     = 128;
    localparam int DEF_CHUNK_SIZE = 8;
    localparam int DEF_EN_BITS    = 3;
    localparam int DEF_NUM_PAIRS  = 4;
    localparam int DEF_PAIR_W     = DEF_EN_BITS + DEF_CHUNK_SIZE;

    // Packet-level state: waiting for a head, or stepping through body flits.
    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } seq_state_t;

    // Width of one base/encoding pair.
    function automatic int pair_width(input int chunk_size, input int en_bits);
        return chunk_size + en_bits;
    endfunction

    // Most significant bit of pair p inside the metadata field; pair 0 sits on top.
    function automatic int pair_msb(input int p, input int num_pairs, input int pair_w);
        return (num_pairs - p) * pair_w - 1;
    endfunction

    // Width of a counter that indexes num_pairs entries (at least one bit).
    function automatic int idx_width(input int num_pairs);
        return (num_pairs > 1) ? $clog2(num_pairs) : 1;
    endfunction

endpackage

// File: rtl/decomp_meta_reg.sv
// Metadata latch for the current packet. Holds the base/encoding pairs taken
// from the head flit and presents the pair selected by the sequencer's counter.
module decomp_meta_reg
    import decomp_pkg::*;
#(
    parameter int  CHUNK_SIZE = DEF_CHUNK_SIZE,
    parameter int  EN_BITS    = DEF_EN_BITS,
    parameter int  NUM_PAIRS  = DEF_NUM_PAIRS,
    localparam int PAIR_W     = pair_width(CHUNK_SIZE, EN_BITS),
    localparam int META_W     = NUM_PAIRS * PAIR_W,
    localparam int IDX_W      = idx_width(NUM_PAIRS)
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [META_W-1:0]     load_data,
    input  logic [IDX_W-1:0]      sel,
    output logic [EN_BITS-1:0]    en,
    output logic [CHUNK_SIZE-1:0] base
);

    logic [META_W-1:0] meta_reg;
    logic [PAIR_W-1:0] pair_arr [NUM_PAIRS];
    logic [PAIR_W-1:0] pair_sel;

    // Capture the metadata field of a multi-flit head; otherwise hold.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
        end else if (load) begin
            meta_reg <= load_data;
        end
    end

    // Split the latched field into pairs, pair 0 being the most significant.
    generate
        for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
            assign pair_arr[gi] = meta_reg[pair_msb(gi, NUM_PAIRS, PAIR_W) -: PAIR_W];
        end
    endgenerate

    // Present the pair the sequencer is currently pointing at.
    always_comb begin
        pair_sel = pair_arr[sel];
    end

    assign en   = pair_sel[PAIR_W-1:CHUNK_SIZE];
    assign base = pair_sel[CHUNK_SIZE-1:0];

endmodule

// File: rtl/decomp_flit_sequencer.sv
// Per-packet controller for the flit decompressor. Latches head metadata,
// walks one base/encoding pair per body flit, feeds the datapath and registers
// its result into a single valid/ready output stage.
module decomp_flit_sequencer
    import decomp_pkg::*;
#(
    parameter int FLIT_W     = DEF_FLIT_W,
    parameter int CHUNK_SIZE = DEF_CHUNK_SIZE,
    parameter int EN_BITS    = DEF_EN_BITS,
    parameter int NUM_PAIRS  = DEF_NUM_PAIRS
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_head,
    input  logic                  in_is_tail,
    input  logic [FLIT_W-1:0]     in_data,
    output logic [FLIT_W-1:0]     dp_data,
    output logic [EN_BITS-1:0]    dp_en_bits,
    output logic [CHUNK_SIZE-1:0] dp_base,
    input  logic [FLIT_W-1:0]     dp_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_is_head,
    output logic                  out_is_tail,
    output logic [FLIT_W-1:0]     out_data,
    output logic                  err_orphan,
    output logic                  err_notail
);

    localparam int PAIR_W = pair_width(CHUNK_SIZE, EN_BITS);
    localparam int META_W = NUM_PAIRS * PAIR_W;
    localparam int IDX_W  = idx_width(NUM_PAIRS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAIRS - 1);

    seq_state_t        state_reg;
    logic [IDX_W-1:0]  pair_idx_reg;
    logic [IDX_W-1:0]  pair_idx_next;
    logic              out_valid_reg;
    logic              out_is_head_reg;
    logic              out_is_tail_reg;
    logic [FLIT_W-1:0] out_data_reg;
    logic              err_orphan_reg;
    logic              err_notail_reg;

    logic accept;
    logic meta_load;

    // The output stage can take a flit when empty or when it drains this cycle.
    assign in_ready  = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready;
    // Only a head that opens a multi-flit packet replaces the metadata;
    // a single-flit packet leaves the previous metadata in place.
    assign meta_load = accept && in_is_head && !in_is_tail;

    assign dp_data = in_data;

    decomp_meta_reg #(
        .CHUNK_SIZE (CHUNK_SIZE),
        .EN_BITS    (EN_BITS),
        .NUM_PAIRS  (NUM_PAIRS)
    ) u_meta (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .load      (meta_load),
        .load_data (in_data[META_W-1:0]),
        .sel       (pair_idx_reg),
        .en        (dp_en_bits),
        .base      (dp_base)
    );

    // Pair counter advance, wrapping after the last pair.
    always_comb begin
        pair_idx_next = pair_idx_reg + 1'b1;
        if (pair_idx_reg == LAST_IDX) begin
            pair_idx_next = '0;
        end
    end

    // Packet FSM, pair counter, output register and sticky error flags.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pair_idx_reg    <= '0;
            out_valid_reg   <= 1'b0;
            out_is_head_reg <= 1'b0;
            out_is_tail_reg <= 1'b0;
            out_data_reg    <= '0;
            err_orphan_reg  <= 1'b0;
            err_notail_reg  <= 1'b0;
        end else if (accept) begin
            if (in_is_head) begin
                // A head while inside a packet means the previous tail never came;
                // flag it and start over with the new packet.
                if (state_reg == BODY) begin
                    err_notail_reg <= 1'b1;
                end
                out_valid_reg   <= 1'b1;
                out_is_head_reg <= 1'b1;
                out_is_tail_reg <= in_is_tail;
                out_data_reg    <= in_data;
                if (in_is_tail) begin
                    state_reg <= IDLE;
                end else begin
                    state_reg    <= BODY;
                    pair_idx_reg <= '0;
                end
            end else if (state_reg == BODY) begin
                out_valid_reg   <= 1'b1;
                out_is_head_reg <= 1'b0;
                out_is_tail_reg <= in_is_tail;
                out_data_reg    <= dp_result;
                pair_idx_reg    <= pair_idx_next;
                if (in_is_tail) begin
                    state_reg <= IDLE;
                end
            end else begin
                // Body with no open packet: consume and drop it. Any flit that was
                // held is draining this cycle, so the stage empties.
                err_orphan_reg <= 1'b1;
                out_valid_reg  <= 1'b0;
            end
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_is_head = out_is_head_reg;
    assign out_is_tail = out_is_tail_reg;
    assign out_data    = out_data_reg;
    assign err_orphan  = err_orphan_reg;
    assign err_notail  = err_notail_reg;

endmodule
